do_pixel_filter: RTL

DO_PIXEL_FILTER -- requirements
Module: do_pixel_filter

---
 rtl/do_pixel_filter.sv | 98 +++++++++
 1 files changed

// File: rtl/do_pixel_filter.sv
// do_pixel_filter: streams a frame buffer through a per-pixel filter (gray/invert/binarize/pass), one pixel per clock.
// Binarize mode is only implemented when PIXEL_FILTER_BINARIZE_EN is defined; otherwise mode 10 passes pixels through.
module do_pixel_filter #(
    parameter int CH_W       = 4,
    parameter int ADDR_W     = 17,
    parameter int NUM_PIXELS = 76800,
    parameter int RD_LAT     = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_filter,
    input  logic [1:0]          mode_i,
    input  logic [CH_W-1:0]     thresh_i,
    output logic                led_done,
    output logic                busy_o,
    output logic [ADDR_W-1:0]   rdaddr_buf1,
    input  logic [3*CH_W-1:0]   din_buf1,
    output logic [ADDR_W-1:0]   wraddr_buf1,
    output logic [3*CH_W-1:0]   dout_buf1,
    output logic                we_buf1
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_PIXELS - 1);
    state_t                state;
    logic [1:0]            mode;
    logic [RD_LAT-1:0]     pv;
    logic [ADDR_W-1:0]     pa [RD_LAT];
    logic [CH_W-1:0]       r, g, b, gray;
    logic [CH_W+7:0]       pr, pg, pb;
    logic [CH_W+9:0]       sum;
    logic [3*CH_W-1:0]     res;
`ifdef PIXEL_FILTER_BINARIZE_EN
    logic [CH_W-1:0]       thresh;
`else
    logic                  unused_thresh;
    assign unused_thresh = ^thresh_i;
`endif
    assign {r, g, b} = din_buf1;
    assign pr   = (CH_W+8)'(r) * (CH_W+8)'(77);
    assign pg   = (CH_W+8)'(g) * (CH_W+8)'(150);
    assign pb   = (CH_W+8)'(b) * (CH_W+8)'(29);
    assign sum  = {2'b0, pr} + {2'b0, pg} + {2'b0, pb};
    assign gray = CH_W'(sum >> 8);
    assign res  = (mode == 2'b00) ? {3{gray}} :
                  (mode == 2'b01) ? ~din_buf1 :
`ifdef PIXEL_FILTER_BINARIZE_EN
                  (mode == 2'b10) ? {(3*CH_W){gray >= thresh}} :
`endif
                  din_buf1;
    // pv/pa carry each issued address alongside its read until the data returns
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            led_done    <= 1'b0;
            busy_o      <= 1'b0;
            we_buf1     <= 1'b0;
            rdaddr_buf1 <= '0;
            wraddr_buf1 <= '0;
            dout_buf1   <= '0;
            pv          <= '0;
            mode        <= 2'b00;
`ifdef PIXEL_FILTER_BINARIZE_EN
            thresh      <= '0;
`endif
        end else begin
            pv[0] <= (state == RUN);
            pa[0] <= rdaddr_buf1;
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
            we_buf1     <= pv[RD_LAT-1];
            wraddr_buf1 <= pa[RD_LAT-1];
            dout_buf1   <= res;
            case (state)
                IDLE: if (enable_filter) begin
                    state       <= RUN;
                    busy_o      <= 1'b1;
                    led_done    <= 1'b0;
                    rdaddr_buf1 <= '0;
                    mode        <= mode_i;
`ifdef PIXEL_FILTER_BINARIZE_EN
                    thresh      <= thresh_i;
`endif
                end
                RUN: if (rdaddr_buf1 == LAST) state <= DRAIN;
                     else rdaddr_buf1 <= rdaddr_buf1 + 1'b1;
                DRAIN: if (we_buf1 && wraddr_buf1 == LAST) begin
                    state    <= DONE;
                    busy_o   <= 1'b0;
                    led_done <= 1'b1;
                end
                DONE: if (!enable_filter) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
